// File: rtl/fifo_serializer_pkg.sv
// rtl/fifo_serializer_pkg.sv - shared types and constants for the FIFO word serializer
package fifo_serializer_pkg;

   typedef enum logic {ST_IDLE, ST_SHIFT} ser_state_t;

   localparam int WORD_CNT_W = 16;

endpackage

// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - pops FIFO words and emits them as OUT_W-wide valid/ready beats
// Optional completed-word counter port word_cnt_o under FIFO_SERIALIZER_WORD_CNT_EN.
module fifo_serializer
   import fifo_serializer_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 2,
   parameter int MSB_FIRST = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             fifo_empty_i,
   input  logic [IN_W-1:0]  fifo_data_i,
   output logic             fifo_rd_en_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [OUT_W-1:0] data_o,
   output logic             last_o,
   output logic             busy_o
`ifdef FIFO_SERIALIZER_WORD_CNT_EN
   ,
   output logic [WORD_CNT_W-1:0] word_cnt_o
`endif
);

   localparam int N_BEATS = IN_W / OUT_W;
   localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

   if (IN_W % OUT_W != 0) begin : g_bad_width
      $error("fifo_serializer: IN_W must be a multiple of OUT_W");
   end

   ser_state_t        state_q;
   ser_state_t        state_d;
   logic [IN_W-1:0]   shift_q;
   logic [CNT_W-1:0]  beat_cnt;
   logic              rd_en;
   logic              valid;
   logic              hs;
   logic              last_beat;
   logic [OUT_W-1:0]  beat;
   logic [IN_W-1:0]   shift_next;

   assign valid     = (state_q == ST_SHIFT);
   assign hs        = valid && ready_i;
   assign last_beat = (beat_cnt == CNT_W'(N_BEATS - 1));

   // The output end is the LSB for LSB-first order and the MSB otherwise.
   if (MSB_FIRST != 0) begin : g_msb
      assign beat       = shift_q[IN_W-1 -: OUT_W];
      assign shift_next = shift_q << OUT_W;
   end else begin : g_lsb
      assign beat       = shift_q[OUT_W-1:0];
      assign shift_next = shift_q >> OUT_W;
   end

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            rd_en = ~fifo_empty_i;
            if (!fifo_empty_i) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Reloading on the final handshake keeps words back-to-back.
            if (hs && last_beat) begin
               rd_en = ~fifo_empty_i;
               if (fifo_empty_i) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         beat_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (rd_en) begin
            shift_q  <= fifo_data_i;
            beat_cnt <= '0;
         end else if (hs && !last_beat) begin
            shift_q  <= shift_next;
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

   assign fifo_rd_en_o = rd_en;
   assign valid_o      = valid;
   assign busy_o       = valid;
   assign data_o       = valid ? beat : '0;
   assign last_o       = valid && last_beat;

`ifdef FIFO_SERIALIZER_WORD_CNT_EN
   logic [WORD_CNT_W-1:0] word_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_cnt_q <= '0;
      end else if (hs && last_beat) begin
         word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
      end
   end

   assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_serializer.sv
// tb/tb_fifo_serializer.sv - randomized self-checking bench for fifo_serializer (LSB and MSB-first)
module tb_fifo_serializer;

   localparam int IN_W    = 8;
   localparam int OUT_W   = 2;
   localparam int N_BEATS = IN_W / OUT_W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             fifo_empty;
   logic [IN_W-1:0]  fifo_data;
   logic             ready;
   logic             rd_a, valid_a, last_a, busy_a;
   logic             rd_b, valid_b, last_b, busy_b;
   logic [OUT_W-1:0] data_a, data_b;
`ifdef FIFO_SERIALIZER_WORD_CNT_EN
   logic [15:0]      wcnt_a, wcnt_b;
`endif

   always #5 clk = ~clk;

   fifo_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(0)) dut_lsb (
      .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
      .fifo_rd_en_o(rd_a), .valid_o(valid_a), .ready_i(ready), .data_o(data_a),
      .last_o(last_a), .busy_o(busy_a)
`ifdef FIFO_SERIALIZER_WORD_CNT_EN
      , .word_cnt_o(wcnt_a)
`endif
   );

   fifo_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1)) dut_msb (
      .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
      .fifo_rd_en_o(rd_b), .valid_o(valid_b), .ready_i(ready), .data_o(data_b),
      .last_o(last_b), .busy_o(busy_b)
`ifdef FIFO_SERIALIZER_WORD_CNT_EN
      , .word_cnt_o(wcnt_b)
`endif
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   // Reference: the FIFO is a queue, the serializer holds one word with rem beats left.
   logic [IN_W-1:0] q[$];
   logic [IN_W-1:0] cur_word;
   int              rem    = 0;
   int              wcnt   = 0;
   bit              chk_en = 0;

   function automatic logic [OUT_W-1:0] exp_beat(input logic [IN_W-1:0] w, input int idx, input bit msb);
      logic [IN_W-1:0] s;
      s = msb ? (w >> (IN_W - OUT_W * (idx + 1))) : (w >> (OUT_W * idx));
      return s[OUT_W-1:0];
   endfunction

   task automatic refresh();
      fifo_empty = (q.size() == 0);
      fifo_data  = fifo_empty ? '0 : q[0];
   endtask

   task automatic push(input logic [IN_W-1:0] w);
      q.push_back(w);
      refresh();
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      bit do_pop, do_hs;
      if (rst_n) begin
         do_hs  = (rem > 0) && ready;
         do_pop = (q.size() > 0) && (rem == 0 || (ready && rem == 1));
         #1;
         if (do_hs && rem == 1) wcnt = (wcnt + 1) % 65536;
         if (do_pop) begin
            cur_word = q.pop_front();
            rem = N_BEATS;
            refresh();
         end else if (do_hs) begin
            rem--;
         end
      end
   end

   always @(negedge clk) begin
      bit exp_valid, exp_rd;
      if (chk_en && rst_n) begin
         exp_valid = (rem > 0);
         exp_rd    = (q.size() > 0) && (rem == 0 || (ready && rem == 1));
         check("valid_lsb", valid_a, exp_valid);
         check("valid_msb", valid_b, exp_valid);
         check("busy_lsb", busy_a, exp_valid);
         check("rd_en_lsb", rd_a, exp_rd);
         check("rd_en_msb", rd_b, exp_rd);
         if (exp_valid) begin
            check("data_lsb", data_a, exp_beat(cur_word, N_BEATS - rem, 1'b0));
            check("data_msb", data_b, exp_beat(cur_word, N_BEATS - rem, 1'b1));
            check("last_lsb", last_a, rem == 1);
            check("last_msb", last_b, rem == 1);
         end
`ifdef FIFO_SERIALIZER_WORD_CNT_EN
         check("word_cnt_lsb", wcnt_a, wcnt);
         check("word_cnt_msb", wcnt_b, wcnt);
`endif
      end
   end

   logic [OUT_W-1:0] got_a[8], got_b[8];
   logic             got_la[8];
   logic [OUT_W-1:0] exp_a[8]  = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
   logic [OUT_W-1:0] exp_b[8]  = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
   logic             exp_la[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int nb, nrd, first, lastc, pct;
      bit seen, done;

      rst_n = 1'b0;
      ready = 1'b0;
      refresh();
      #3;
      check("reset_valid", valid_a, 1'b0);
      check("reset_rd_en", rd_a, 1'b0);
      check("reset_data", data_a, 2'd0);
      check("reset_last", last_a, 1'b0);
      check("reset_busy", busy_b, 1'b0);
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Back-to-back 0xB4, 0x1E at full rate.
      step();
      push(8'hB4);
      push(8'h1E);
      ready = 1'b1;
      nb = 0; nrd = 0; first = -1; lastc = -1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rd_a) nrd++;
         if (valid_a && nb < 8) begin
            got_a[nb] = data_a; got_b[nb] = data_b; got_la[nb] = last_a;
            nb++;
            if (first < 0) first = c;
            lastc = c;
         end
      end
      check("b2b_beat_count", nb, 8);
      check("b2b_no_gap", lastc - first + 1, 8);
      check("b2b_rd_pulses", nrd, 2);
      for (int i = 0; i < 8; i++) begin
         check("b2b_lsb_beat", got_a[i], exp_a[i]);
         check("b2b_msb_beat", got_b[i], exp_b[i]);
         check("b2b_last", got_la[i], exp_la[i]);
      end

      // Backpressure on beat 1 for three cycles.
      step();
      push(8'hB4);
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = valid_a;
      end
      check("bp_first_valid", seen, 1'b1);
      check("bp_beat0", data_a, 2'd0);
      step();
      ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_hold_data", data_a, 2'd1);
         check("bp_hold_valid", valid_a, 1'b1);
         check("bp_hold_msb", data_b, 2'd3);
      end
      step();
      ready = 1'b1;
      @(negedge clk);
      check("bp_release_beat1", data_a, 2'd1);
      step();
      @(negedge clk);
      check("bp_resume_beat2", data_a, 2'd3);
      repeat (4) step();

      // Empty FIFO with random ready.
      for (int c = 0; c < 20; c++) begin
         step();
         ready = $urandom_range(0, 1);
         @(negedge clk);
         check("empty_rd_en", rd_a | rd_b, 1'b0);
         check("empty_valid", valid_a | valid_b, 1'b0);
      end

      // Reset after beat 1 of a word.
      step();
      ready = 1'b1;
      push(8'hB4);
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = valid_a;
      end
      @(negedge clk);
      check("rst_pre_beat1", data_a, 2'd1);
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("rst_async_valid_lsb", valid_a, 1'b0);
      check("rst_async_valid_msb", valid_b, 1'b0);
      rem = 0;
      wcnt = 0;
      q.delete();
      refresh();
      step();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("post_rst_idle", valid_a | valid_b, 1'b0);
      end
`ifdef FIFO_SERIALIZER_WORD_CNT_EN
      check("word_cnt_after_rst", wcnt_a, 16'd0);
      step();
      push(8'h11); push(8'h22); push(8'h33);
      repeat (16) step();
      check("word_cnt_three", wcnt_a, 16'd3);
`endif

      // Random traffic with varying backpressure.
      for (int seg = 0; seg < 8; seg++) begin
         pct = (seg % 4 == 0) ? 100 : (seg % 4 == 1) ? 50 : (seg % 4 == 2) ? 85 : 20;
         for (int c = 0; c < 400; c++) begin
            step();
            ready = ($urandom_range(0, 99) < pct);
            if (q.size() < 6 && $urandom_range(0, 99) < 45) push(IN_W'($urandom));
         end
      end

      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         step();
         ready = 1'b1;
         done = (q.size() == 0) && (rem == 0);
      end
      check("drain_complete", done, 1'b1);
      repeat (2) step();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
